calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
// PURPOSE
// - Front-end controller for the registered 4-bit calculator ALU.
// - One switch bank plus a load key enter operand A, operand B, then the opcode.
// - Drives the ALU operand/opcode inputs and waits out the ALU register latency.
// - Captures and holds the result for the 7-segment display path.
// PARAMETERS
// - W        4  operand/result width; matches ALU width
// - ALU_LAT  1  ALU output register latency in cycles; >=1
// PORTS
// - clk          in   1   system clock; all state updates on rising edge
// - rst_n        in   1   synchronous reset, active-low
// - ena          in   1   design enable; low freezes the FSM and all registers
// - load         in   1   load key, level; the block detects its rising edge internally
// - chain        in   1   with CALC_SEQ_CHAIN_EN: reuse previous result as A; otherwise ignored
// - data_in      in   W   operand value from the switches
// - op_in        in   2   opcode from switches: 00 add, 01 sub, 10 or, 11 a!=b
// - alu_a        out  W   operand A to the ALU
// - alu_b        out  W   operand B to the ALU
// - alu_op       out  2   opcode to the ALU
// - alu_result   in   W   registered ALU output
// - result       out  W   held result for display
// - result_valid out  1   high while in S_SHOW
// - busy         out  1   high while in S_WAIT
// - state        out  3   FSM state for debug LEDs
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - state=S_A; alu_a, alu_b, alu_op, result, wait counter and load-edge history all 0.
//   - result_valid=0, busy=0.
//   - Reset overrides ena and any operation in progress, including mid-S_WAIT; no partial result survives.
// - Load-edge detector:
//   - load_q registers load every cycle that ena=1.
//   - ld_edge = load & ~load_q.
//   - A held key yields exactly one ld_edge.
//   - Edges while ena=0 are discarded; load_q is not updated while ena=0.
// - State encoding: S_A=0, S_B=1, S_OP=2, S_WAIT=3, S_SHOW=4; codes 5-7 recover to S_A on the next edge.
// - Transitions (only when ena=1):
//   - S_A, ld_edge: alu_a<=data_in; go to S_B.
//   - S_B, ld_edge: alu_b<=data_in; go to S_OP.
//   - S_OP, ld_edge: alu_op<=op_in; cnt<=ALU_LAT; go to S_WAIT.
//   - S_WAIT, cnt!=0: cnt<=cnt-1. ld_edge is ignored and not queued.
//   - S_WAIT, cnt==0: result<=alu_result; go to S_SHOW.
//   - S_SHOW, ld_edge: alu_a<=data_in; go to S_B. result keeps its old value until the next capture.
// - Latency: result is captured on the (ALU_LAT+1)th rising edge after the opcode-capture edge.
//   - result_valid rises on that same edge.
//   - result_valid falls on the edge that leaves S_SHOW.
// - alu_a, alu_b and alu_op hold steady through S_WAIT and S_SHOW; they change only on their capture edges.
// - Arithmetic lives in the ALU; this block passes W-bit values through unchanged (sub wraps modulo 2^W).
// - Counter width is $clog2(ALU_LAT+1); it holds 0 outside S_WAIT.
// CONFIGURATION
// - CALC_SEQ_CHAIN_EN defined:
//   - In S_SHOW, ld_edge with chain=1 sets alu_a<=result (data_in ignored) and goes to S_B.
//   - ld_edge with chain=0 behaves as in the base behaviour.
// - CALC_SEQ_CHAIN_EN undefined:
//   - chain is unused.
//   - S_SHOW ld_edge always loads alu_a from data_in.
// TESTING
// - Add: A=3, B=5, op=00, ALU_LAT=1
//   -> alu_a=3, alu_b=5, alu_op=00; result=8 and result_valid=1 exactly 2 edges after the op edge; busy=1 for 2 cycles.
// - Sub wrap: A=3, B=5, op=01 -> result=4'hE.
// - Compare: A=7, B=7, op=11 -> result=0.
// - Held key: load high for 10 cycles in S_A -> only A captured; state stays S_B.
// - Key during wait: ld_edge in S_WAIT ignored -> result=8 on schedule; state S_SHOW; alu_a unchanged.
// - Reset mid-S_WAIT: rst_n=0 for 1 cycle -> next cycle state=0, result=0, result_valid=0, busy=0.
// - ena=0 then load pulse -> state and all outputs frozen, edge discarded.
// - With CALC_SEQ_CHAIN_EN, after result=8: chain=1 load, B=1, op=00 -> result=9, alu_a=8.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Operand/opcode entry sequencer for the registered calculator ALU; captures and holds the result.
// Optional feature: define CALC_SEQ_CHAIN_EN to let a chained load reuse the held result as operand A.
module calc_op_sequencer #(
  parameter int W       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         load,
  input  logic         chain,
  input  logic [W-1:0] data_in,
  input  logic [1:0]   op_in,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         busy,
  output logic [2:0]   state
);

  localparam int unsigned CW = $clog2(ALU_LAT + 1);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  logic [2:0]    state_q,  state_d;
  logic [W-1:0]  alu_a_q,  alu_a_d;
  logic [W-1:0]  alu_b_q,  alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          load_q,   load_d;
  logic          ld_edge;

`ifndef CALC_SEQ_CHAIN_EN
  logic unused_chain;
  assign unused_chain = chain;
`endif

  assign ld_edge = load & ~load_q;

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    if (ena) begin
      load_d = load;
      case (state_q)
        S_A: if (ld_edge) begin
          alu_a_d = data_in;
          state_d = S_B;
        end
        S_B: if (ld_edge) begin
          alu_b_d = data_in;
          state_d = S_OP;
        end
        S_OP: if (ld_edge) begin
          alu_op_d = op_in;
          cnt_d    = CW'(ALU_LAT);
          state_d  = S_WAIT;
        end
        // Key presses here are dropped; the counter alone paces the capture.
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            result_d = alu_result;
            state_d  = S_SHOW;
          end
        end
        S_SHOW: if (ld_edge) begin
`ifdef CALC_SEQ_CHAIN_EN
          alu_a_d = chain ? result_q : data_in;
`else
          alu_a_d = data_in;
`endif
          state_d = S_B;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_A;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_valid = (state_q == S_SHOW);
  assign busy         = (state_q == S_WAIT);
  assign state        = state_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with a registered ALU stub.
module tb_calc_op_sequencer;
  localparam int W       = 4;
  localparam int ALU_LAT = 1;

  logic         clk = 1'b0;
  logic         rst_n, ena, load, chain;
  logic [W-1:0] data_in;
  logic [1:0]   op_in;
  logic [W-1:0] alu_a, alu_b, result;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_res = '0;
  logic         result_valid, busy;
  logic [2:0]   state;

  int unsigned  n_total = 0;
  int unsigned  n_bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res = '0;
  logic         rv_seen  = 1'b0;

  calc_op_sequencer #(.W(W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .chain(chain),
    .data_in(data_in), .op_in(op_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_res), .result(result),
    .result_valid(result_valid), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a | b;
      default: return (a != b) ? W'(1) : W'(0);
    endcase
  endfunction

  // Registered ALU with one cycle of latency.
  always @(posedge clk) alu_res <= alu_model(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && result_valid && !rv_seen) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("result", result, exp_q.pop_front());
    end
    rv_seen = result_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [W-1:0] d, input logic ch);
    data_in = d; chain = ch; load = 1'b1;
    step();
    load = 1'b0; chain = 1'b0;
    step();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic ch, input logic key_wait);
    logic [W-1:0] ea;
    int n, busy_n;
    ea = a;
`ifdef CALC_SEQ_CHAIN_EN
    if (ch) ea = last_res;
`endif
    press(a, ch);
    check("alu_a", alu_a, ea);
    press(b, 1'b0);
    check("alu_b", alu_b, b);
    op_in = op; load = 1'b1;
    last_res = alu_model(ea, b, op);
    exp_q.push_back(last_res);
    step();
    load = 1'b0;
    check("alu_op", alu_op, op);
    check("state_wait", state, 3);
    n = 0; busy_n = 0;
    while (!result_valid && n < 10) begin
      if (busy) busy_n++;
      if (key_wait && n == 1) begin
        load = 1'b1; data_in = 4'h9;
      end
      step();
      n++;
    end
    check("latency", n, ALU_LAT + 1);
    check("busy_cycles", busy_n, ALU_LAT + 1);
    check("state_show", state, 4);
    check("alu_a_hold", alu_a, ea);
    check("alu_op_hold", alu_op, op);
    load = 1'b0;
    step();
    check("rv_hold", result_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; load = 1'b0; chain = 1'b0; data_in = '0; op_in = '0;
    step(); step();
    check("rst_state", state, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ops", {alu_a, alu_b, alu_op}, 0);
    rst_n = 1'b1;
    step();

    run_op(4'h3, 4'h5, 2'b00, 1'b0, 1'b0);
    run_op(4'h3, 4'h5, 2'b01, 1'b0, 1'b0);
    run_op(4'h7, 4'h7, 2'b11, 1'b0, 1'b0);
    run_op(4'h7, 4'h2, 2'b11, 1'b0, 1'b0);
    run_op(4'hA, 4'h5, 2'b10, 1'b0, 1'b0);
    run_op(4'h3, 4'h5, 2'b00, 1'b0, 1'b1);

    // Frozen while disabled; the pulse must not be remembered.
    ena = 1'b0; data_in = 4'hC; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    check("ena0_state", state, 4);
    check("ena0_alu_a", alu_a, 4'h3);
    check("ena0_result", result, 4'h8);
    ena = 1'b1;
    step();
    check("ena1_state", state, 4);

    run_op(4'h6, 4'h1, 2'b00, 1'b1, 1'b0);

    // Reset while waiting on the ALU.
    press(4'h2, 1'b0);
    press(4'h3, 1'b0);
    op_in = 2'b00; load = 1'b1;
    step();
    load = 1'b0;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_state", state, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_rv", result_valid, 0);
    check("mid_rst_busy", busy, 0);
    step(); step();
    check("mid_rst_stay", state, 0);

    data_in = 4'h6; load = 1'b1;
    step();
    data_in = 4'h2;
    repeat (9) step();
    check("held_state", state, 1);
    check("held_alu_a", alu_a, 4'h6);
    load = 1'b0;
    step();

    check("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
